isram_axi_rd: RTL

- AXI4 read-only slave that models the instruction SRAM feeding the instruction-fetch stage.
- Accepts one read address request at a time and waits a programmable latency.
- Returns one or more data beats with AXI response, ID and last signalling.
- Sits directly upstream of the fetch unit's AR/R channel; boot code is preloaded at BASE_ADDR.

---
 rtl/isram_axi_rd_if.sv | 30 +++
 rtl/isram_axi_rd.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/isram_axi_rd_if.sv
// AR/R channel bundle between the fetch unit (master) and the instruction SRAM (slave).
// Handshake: a beat transfers on a rising edge where valid && ready; the source holds payload stable while valid && !ready.
interface isram_axi_rd_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  arvalid;
   logic                  arready;
   logic [3:0]            arid;
   logic [7:0]            arlen;
   logic [2:0]            arsize;
   logic [1:0]            arburst;
   logic [ADDR_WIDTH-1:0] araddr;
   logic                  rvalid;
   logic                  rready;
   logic [DATA_WIDTH-1:0] rdata;
   logic [1:0]            rresp;
   logic                  rlast;
   logic [3:0]            rid;

   modport master (
      output arvalid, arid, arlen, arsize, arburst, araddr, rready,
      input  arready, rvalid, rdata, rresp, rlast, rid
   );

   modport slave (
      input  arvalid, arid, arlen, arsize, arburst, araddr, rready,
      output arready, rvalid, rdata, rresp, rlast, rid
   );
endinterface

// File: rtl/isram_axi_rd.sv
// AXI4 read-only instruction SRAM: one outstanding AR, LATENCY cycles to first beat, per-beat OKAY/SLVERR/DECERR.
// Optional macro ISRAM_RAND_DELAY_EN inserts 0..7 LFSR-chosen idle cycles before every beat.
module isram_axi_rd #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h3000_0000,
   parameter int                    DEPTH      = 4096,
   parameter int                    LATENCY    = 2,
   parameter string                 INIT_FILE  = ""
) (
   input  logic               clk,
   input  logic               rst,
   isram_axi_rd_if.slave      bus,
   output logic [1:0]         o_dbg_state
);
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_DATA = 2'd2} state_t;

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam int AW1   = ADDR_WIDTH + 1;
   localparam logic [AW1-1:0] LIMIT = AW1'({1'b0, BASE_ADDR}) + AW1'(4 * DEPTH);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   state_t                r_state, w_state_nxt;
   logic [CNT_W-1:0]      r_cnt;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [7:0]            r_len, r_beat;
   logic [2:0]            r_size;
   logic [1:0]            r_burst;
   logic [3:0]            r_id;
   logic                  r_rvalid, r_rlast;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic [1:0]            r_rresp;
   logic [3:0]            r_rid;

   logic                  w_ar_hs, w_r_hs, w_load, w_misalign, w_slverr, w_in_range;
   logic [ADDR_WIDTH-1:0] w_next_addr, w_beat_addr;
   logic [7:0]            w_beat_num;
   logic [1:0]            w_bresp, w_mask;
   logic [DATA_WIDTH-1:0] w_bdata;
   logic [2:0]            w_extra;

`ifdef ISRAM_RAND_DELAY_EN
   logic [15:0] r_lfsr;
   logic [2:0]  r_dly;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_lfsr <= 16'hACE1;
      else      r_lfsr <= {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
   end
   assign w_extra = r_lfsr[2:0];
`else
   assign w_extra = 3'd0;
`endif

   assign bus.arready = rst && (r_state == S_IDLE);
   assign w_ar_hs     = bus.arvalid && bus.arready;
   assign w_r_hs      = r_rvalid && bus.rready;
   // A beat is (re)computed when the latency expires or when a non-final beat is accepted.
   assign w_load      = ((r_state == S_WAIT) && (r_cnt == '0)) ||
                        ((r_state == S_DATA) && w_r_hs && !r_rlast);
   assign w_next_addr = (r_burst == 2'b01) ? r_addr + (ADDR_WIDTH'(1) << r_size) : r_addr;
   assign w_beat_addr = (r_state == S_WAIT) ? r_addr : w_next_addr;
   assign w_beat_num  = (r_state == S_WAIT) ? 8'd0 : r_beat + 8'd1;

   assign w_mask      = (r_size == 3'd0) ? 2'b00 : (r_size == 3'd1) ? 2'b01 : 2'b11;
   assign w_misalign  = |(w_beat_addr[1:0] & w_mask);
   assign w_slverr    = (r_size > 3'd2) || r_burst[1] || w_misalign;
   assign w_in_range  = (w_beat_addr >= BASE_ADDR) && ({1'b0, w_beat_addr} < LIMIT);
   assign w_bresp     = w_slverr ? 2'd2 : (!w_in_range ? 2'd3 : 2'd0);
   assign w_bdata     = (w_bresp == 2'd0) ? r_mem[IDX_W'((w_beat_addr - BASE_ADDR) >> 2)] : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_ar_hs) w_state_nxt = S_WAIT;
         S_WAIT:  if (r_cnt == '0) w_state_nxt = S_DATA;
         S_DATA:  if (w_r_hs && r_rlast) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt    <= '0;
         r_beat   <= '0;
         r_addr   <= '0;
         r_len    <= '0;
         r_size   <= '0;
         r_burst  <= '0;
         r_id     <= '0;
         r_rvalid <= 1'b0;
         r_rdata  <= '0;
         r_rresp  <= '0;
         r_rlast  <= 1'b0;
         r_rid    <= '0;
`ifdef ISRAM_RAND_DELAY_EN
         r_dly    <= '0;
`endif
      end else begin
         if (w_ar_hs) begin
            r_addr  <= bus.araddr;
            r_id    <= bus.arid;
            r_len   <= bus.arlen;
            r_size  <= bus.arsize;
            r_burst <= bus.arburst;
            r_cnt   <= CNT_W'(LATENCY - 1);
         end else if ((r_state == S_WAIT) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
         end

         if (w_load) begin
            r_addr   <= w_beat_addr;
            r_beat   <= w_beat_num;
            r_rdata  <= w_bdata;
            r_rresp  <= w_bresp;
            r_rlast  <= (w_beat_num == r_len);
            r_rid    <= r_id;
            r_rvalid <= (w_extra == 3'd0);
`ifdef ISRAM_RAND_DELAY_EN
            r_dly    <= w_extra;
`endif
         end else if (w_r_hs) begin
            r_rvalid <= 1'b0;
            r_rlast  <= 1'b0;
         end
`ifdef ISRAM_RAND_DELAY_EN
         else if ((r_state == S_DATA) && !r_rvalid && (r_dly != '0)) begin
            r_dly <= r_dly - 1'b1;
            if (r_dly == 3'd1) r_rvalid <= 1'b1;
         end
`endif
      end
   end

   assign bus.rvalid  = r_rvalid;
   assign bus.rdata   = r_rdata;
   assign bus.rresp   = r_rresp;
   assign bus.rlast   = r_rlast;
   assign bus.rid     = r_rid;
   assign o_dbg_state = r_state;
endmodule
